// File: rtl/mips_hazard_pkg.sv
// ---------------------------------------------------------------------------
// mips_hazard_pkg
// Shared definitions for the ID-stage hazard/stall controller.
//   state_e   : controller FSM states (2-bit encoding)
//   ADDR_*    : next-PC select mux codes driven on addrSel
// ---------------------------------------------------------------------------
package mips_hazard_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_J_FL   = 2'd1,
    S_BR_RES = 2'd2,
    S_BR_FL  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_PC4 = 2'b00;
  localparam logic [1:0] ADDR_JMP = 2'b01;
  localparam logic [1:0] ADDR_BR  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_param_if
// Bundles the pipeline-facing signals of the hazard controller.
//   Inputs to the controller : Jump, Branch, ALUZero, currRs, currRt,
//                              UseShamt, UseImmed, prevRt, memReadX, MemReady
//   Outputs of the controller: PCWrite, IFWrite, Bubble, addrSel, BubbleCnt
// Modports:
//   master : pipeline side (drives decode/EX information, observes controls)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface hazard_ctrl_param_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 16
);

  logic              Jump;
  logic              Branch;
  logic              ALUZero;
  logic [REG_W-1:0]  currRs;
  logic [REG_W-1:0]  currRt;
  logic              UseShamt;
  logic              UseImmed;
  logic [REG_W-1:0]  prevRt;
  logic              memReadX;
  logic              MemReady;

  logic              PCWrite;
  logic              IFWrite;
  logic              Bubble;
  logic [1:0]        addrSel;
  logic [PERF_W-1:0] BubbleCnt;

  modport master (
    output Jump, Branch, ALUZero, currRs, currRt, UseShamt, UseImmed,
           prevRt, memReadX, MemReady,
    input  PCWrite, IFWrite, Bubble, addrSel, BubbleCnt
  );

  modport slave (
    input  Jump, Branch, ALUZero, currRs, currRt, UseShamt, UseImmed,
           prevRt, memReadX, MemReady,
    output PCWrite, IFWrite, Bubble, addrSel, BubbleCnt
  );

endinterface

// File: rtl/load_hazard_window.sv
// ---------------------------------------------------------------------------
// load_hazard_window
// Detects load-use hazards between the ID-stage sources and any load that is
// still inside the load-latency window (the load in EX plus LOAD_LAT-1 older
// loads remembered in a small history shift register).
//   clk, reset  : clock and synchronous active-high reset
//   mem_ready   : 0 freezes the history
//   mem_read_x  : EX instruction is a load
//   prev_rt     : EX destination register
//   curr_rs/rt  : ID source registers
//   use_shamt   : ID instruction ignores rs
//   use_immed   : ID instruction ignores rt
//   ld_haz      : a source of the ID instruction waits on a pending load
// ---------------------------------------------------------------------------
module load_hazard_window #(
  parameter int LOAD_LAT = 1,
  parameter int REG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_ready,
  input  logic             mem_read_x,
  input  logic [REG_W-1:0] prev_rt,
  input  logic [REG_W-1:0] curr_rs,
  input  logic [REG_W-1:0] curr_rt,
  input  logic             use_shamt,
  input  logic             use_immed,
  output logic             ld_haz
);

  // With LOAD_LAT=1 the window is only the EX stage; a single dummy entry is
  // kept so the storage has a legal size, but it is never consulted.
  localparam bit USE_HIST = (LOAD_LAT > 1);
  localparam int HIST_N   = USE_HIST ? LOAD_LAT - 1 : 1;

  logic [HIST_N-1:0] valid_q, valid_d;
  logic [REG_W-1:0]  dst_q [HIST_N];
  logic [REG_W-1:0]  dst_d [HIST_N];
  logic              ex_load;

  // A load into $0 produces nothing to wait for.
  assign ex_load = mem_read_x && (prev_rt != '0);

  function automatic logic src_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             no_rs,
                                     input logic             no_rt);
    return (!no_rs && (rs == dst)) || (!no_rt && (rt == dst));
  endfunction

  // Entry 0 takes the EX-stage load; older entries age by one slot.
  always_comb begin
    valid_d = valid_q;
    dst_d   = dst_q;
    if (mem_ready) begin
      valid_d[0] = ex_load;
      dst_d[0]   = prev_rt;
      for (int i = 1; i < HIST_N; i++) begin
        valid_d[i] = valid_q[i-1];
        dst_d[i]   = dst_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < HIST_N; i++) begin
        dst_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      dst_q   <= dst_d;
    end
  end

  always_comb begin
    ld_haz = ex_load && src_match(prev_rt, curr_rs, curr_rt, use_shamt, use_immed);
    if (USE_HIST) begin
      for (int i = 0; i < HIST_N; i++) begin
        if (valid_q[i] && src_match(dst_q[i], curr_rs, curr_rt, use_shamt, use_immed)) begin
          ld_haz = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_param.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_param
// ID-stage hazard/stall controller for the pipelined MIPS core. Stalls on
// load-use hazards, sequences jump and taken-branch redirects with a
// configurable number of flush bubbles, freezes on memory-not-ready and
// counts bubble cycles in a saturating performance counter.
//   CLK    : clock, all state changes on posedge
//   Reset  : synchronous active-high reset
//   bus    : pipeline signals (see hazard_ctrl_param_if), slave side
// ---------------------------------------------------------------------------
module hazard_ctrl_param
  import mips_hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int J_FLUSH  = 1,
  parameter int PERF_W   = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  hazard_ctrl_param_if.slave  bus
);

  localparam logic [1:0]        J_CNT_INIT  = 2'(J_FLUSH - 1);
  localparam logic [1:0]        BR_CNT_INIT = 2'(BR_FLUSH - 1);
  localparam logic [PERF_W-1:0] PERF_ONE    = PERF_W'(1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic              ld_haz;
  logic              pc_write;
  logic              if_write;
  logic              bubble;
  logic [1:0]        addr_sel;

  load_hazard_window #(
    .LOAD_LAT (LOAD_LAT),
    .REG_W    (REG_W)
  ) u_window (
    .clk        (CLK),
    .reset      (Reset),
    .mem_ready  (bus.MemReady),
    .mem_read_x (bus.memReadX),
    .prev_rt    (bus.prevRt),
    .curr_rs    (bus.currRs),
    .curr_rt    (bus.currRt),
    .use_shamt  (bus.UseShamt),
    .use_immed  (bus.UseImmed),
    .ld_haz     (ld_haz)
  );

  // Next state and control outputs. Jump beats a load stall, which beats a
  // branch because the branch compare needs its operands available.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_write = 1'b1;
    if_write = 1'b1;
    bubble   = 1'b0;
    addr_sel = ADDR_PC4;

    case (state_q)
      S_IDLE: begin
        if (bus.Jump) begin
          if_write = 1'b0;
          addr_sel = ADDR_JMP;
          state_d  = S_J_FL;
          cnt_d    = J_CNT_INIT;
        end else if (ld_haz) begin
          pc_write = 1'b0;
          if_write = 1'b0;
          bubble   = 1'b1;
        end else if (bus.Branch) begin
          pc_write = 1'b0;
          if_write = 1'b0;
          state_d  = S_BR_RES;
        end
      end
      S_BR_RES: begin
        if (bus.ALUZero) begin
          if_write = 1'b0;
          bubble   = 1'b1;
          addr_sel = ADDR_BR;
          state_d  = S_BR_FL;
          cnt_d    = BR_CNT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_J_FL, S_BR_FL: begin
        bubble = 1'b1;
        if (cnt_q == 2'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Memory not ready freezes the whole front end and all controller state.
    if (!bus.MemReady) begin
      pc_write = 1'b0;
      if_write = 1'b0;
      bubble   = 1'b0;
      addr_sel = ADDR_PC4;
      state_d  = state_q;
      cnt_d    = cnt_q;
    end
  end

  // Bubble is already forced low while frozen, so it alone gates counting.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + PERF_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.PCWrite   = pc_write;
  assign bus.IFWrite   = if_write;
  assign bus.Bubble    = bubble;
  assign bus.addrSel   = addr_sel;
  assign bus.BubbleCnt = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_param
// Directed bench for hazard_ctrl_param with two configurations:
//   dut_a : LOAD_LAT=1, BR_FLUSH=2, J_FLUSH=1, PERF_W=16
//   dut_b : LOAD_LAT=3, BR_FLUSH=1, J_FLUSH=2, PERF_W=4
// Control outputs are compared packed as {PCWrite, IFWrite, Bubble, addrSel}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_param;

  // Expected control words {PCWrite, IFWrite, Bubble, addrSel}
  localparam logic [31:0] RUN     = 32'b11_0_00;
  localparam logic [31:0] STALL   = 32'b00_1_00;
  localparam logic [31:0] HOLD    = 32'b00_0_00;
  localparam logic [31:0] JMP     = 32'b10_0_01;
  localparam logic [31:0] BR_TAKE = 32'b10_1_10;
  localparam logic [31:0] FLUSH   = 32'b11_1_00;

  logic clk = 1'b0;
  logic reset;
  int   test_count = 0;
  int   fail_count = 0;

  always #5 clk = ~clk;

  hazard_ctrl_param_if #(.REG_W(5), .PERF_W(16)) bus_a ();
  hazard_ctrl_param_if #(.REG_W(5), .PERF_W(4))  bus_b ();

  hazard_ctrl_param #(
    .REG_W(5), .LOAD_LAT(1), .BR_FLUSH(2), .J_FLUSH(1), .PERF_W(16)
  ) dut_a (
    .CLK   (clk),
    .Reset (reset),
    .bus   (bus_a.slave)
  );

  hazard_ctrl_param #(
    .REG_W(5), .LOAD_LAT(3), .BR_FLUSH(1), .J_FLUSH(2), .PERF_W(4)
  ) dut_b (
    .CLK   (clk),
    .Reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkCtl(input string tag, input bit sel_b, input logic [31:0] exp);
    logic [4:0] ctl;
    if (sel_b) ctl = {bus_b.PCWrite, bus_b.IFWrite, bus_b.Bubble, bus_b.addrSel};
    else       ctl = {bus_a.PCWrite, bus_a.IFWrite, bus_a.Bubble, bus_a.addrSel};
    checkOutput(tag, 32'(ctl), exp);
  endtask

  // Drives one cycle of inputs on the selected DUT and lets them settle.
  task automatic applyStimulus(input bit sel_b, input logic jump, input logic branch,
                               input logic alu_zero, input logic mem_read_x,
                               input logic [4:0] prev_rt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic use_shamt,
                               input logic use_immed, input logic mem_ready);
    if (sel_b) begin
      bus_b.Jump = jump; bus_b.Branch = branch; bus_b.ALUZero = alu_zero;
      bus_b.memReadX = mem_read_x; bus_b.prevRt = prev_rt;
      bus_b.currRs = rs; bus_b.currRt = rt;
      bus_b.UseShamt = use_shamt; bus_b.UseImmed = use_immed;
      bus_b.MemReady = mem_ready;
    end else begin
      bus_a.Jump = jump; bus_a.Branch = branch; bus_a.ALUZero = alu_zero;
      bus_a.memReadX = mem_read_x; bus_a.prevRt = prev_rt;
      bus_a.currRs = rs; bus_a.currRt = rt;
      bus_a.UseShamt = use_shamt; bus_a.UseImmed = use_immed;
      bus_a.MemReady = mem_ready;
    end
    #1;
  endtask

  task automatic nop(input bit sel_b);
    applyStimulus(sel_b, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1;
    nop(0);
    nop(1);
    tick();
    tick();
    #1;
    checkCtl("rst_ctl_a", 0, RUN);
    checkCtl("rst_ctl_b", 1, RUN);
    checkOutput("rst_cnt_a", 32'(bus_a.BubbleCnt), 32'd0);
    checkOutput("rst_cnt_b", 32'(bus_b.BubbleCnt), 32'd0);
    reset = 1'b0;
    tick();

    // ---------------- dut_a: load-use, LOAD_LAT=1 ----------------
    applyStimulus(0, 0, 0, 0, 1, 5, 5, 0, 0, 1, 1);
    checkCtl("a_ld_rs_stall", 0, STALL);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 5, 5, 0, 0, 1, 1);
    checkCtl("a_ld_rs_clear", 0, RUN);
    checkOutput("a_cnt_ld", 32'(bus_a.BubbleCnt), 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 5, 5, 0, 1, 1, 1);
    checkCtl("a_shamt_no_stall", 0, RUN);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 7, 0, 7, 1, 0, 1);
    checkCtl("a_ld_rt_stall", 0, STALL);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 7, 0, 7, 1, 0, 1);
    checkCtl("a_ld_rt_clear", 0, RUN);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 7, 0, 7, 1, 1, 1);
    checkCtl("a_immed_no_stall", 0, RUN);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    checkCtl("a_r0_no_stall", 0, RUN);
    checkOutput("a_cnt_ld2", 32'(bus_a.BubbleCnt), 32'd2);
    tick();

    // ---------------- dut_a: taken branch, BR_FLUSH=2 ----------------
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("a_br_wait", 0, HOLD);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("a_br_taken", 0, BR_TAKE);
    tick();
    nop(0);
    checkCtl("a_br_fl1", 0, FLUSH);
    tick();
    checkCtl("a_br_fl2", 0, FLUSH);
    tick();
    checkCtl("a_br_done", 0, RUN);
    checkOutput("a_cnt_br", 32'(bus_a.BubbleCnt), 32'd5);
    tick();

    // ---------------- dut_a: not-taken branch ----------------
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("a_brnt_wait", 0, HOLD);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("a_brnt_res", 0, RUN);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("a_brnt_idle", 0, RUN);
    checkOutput("a_cnt_brnt", 32'(bus_a.BubbleCnt), 32'd5);
    tick();

    // ---------------- dut_a: jump and branch together ----------------
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("a_jmp_br", 0, JMP);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("a_jfl", 0, FLUSH);
    tick();
    checkCtl("a_jmp_done", 0, RUN);
    checkOutput("a_cnt_jmp", 32'(bus_a.BubbleCnt), 32'd6);
    tick();

    // ---------------- dut_a: freeze during BR_FL ----------------
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("a_frz_br_wait", 0, HOLD);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("a_frz_br_taken", 0, BR_TAKE);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkCtl("a_frz_ctl", 0, HOLD);
      checkOutput("a_frz_cnt", 32'(bus_a.BubbleCnt), 32'd7);
      tick();
    end
    nop(0);
    checkCtl("a_frz_fl1", 0, FLUSH);
    tick();
    checkCtl("a_frz_fl2", 0, FLUSH);
    tick();
    checkCtl("a_frz_done", 0, RUN);
    checkOutput("a_cnt_frz", 32'(bus_a.BubbleCnt), 32'd9);
    tick();

    // ---------------- dut_b: load-use, LOAD_LAT=3 ----------------
    applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0, 1, 1);
    checkCtl("b_ld_stall0", 1, STALL);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 5, 5, 0, 0, 1, 1);
    checkCtl("b_ld_stall1", 1, STALL);
    tick();
    checkCtl("b_ld_stall2", 1, STALL);
    tick();
    checkCtl("b_ld_clear", 1, RUN);
    checkOutput("b_cnt_ld", 32'(bus_b.BubbleCnt), 32'd3);
    tick();
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    checkCtl("b_r0_ex", 1, RUN);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkCtl("b_r0_hist", 1, RUN);
    tick();

    // ---------------- dut_b: history holds while frozen ----------------
    applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0, 1, 1);
    checkCtl("b_frz_ld", 1, STALL);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 5, 5, 0, 0, 1, 0);
      checkCtl("b_frz_ctl", 1, HOLD);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 5, 5, 0, 0, 1, 1);
    checkCtl("b_frz_h0", 1, STALL);
    tick();
    checkCtl("b_frz_h1", 1, STALL);
    tick();
    checkCtl("b_frz_clear", 1, RUN);
    checkOutput("b_cnt_frz", 32'(bus_b.BubbleCnt), 32'd6);
    tick();

    // ---------------- dut_b: counter saturation, PERF_W=4 ----------------
    applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("b_sat_reach", 32'(bus_b.BubbleCnt), 32'd15);
    for (int i = 0; i < 11; i++) tick();
    checkOutput("b_sat_hold", 32'(bus_b.BubbleCnt), 32'd15);
    nop(1);
    for (int i = 0; i < 3; i++) tick();
    checkCtl("b_sat_idle", 1, RUN);

    // ---------------- dut_b: jump, J_FLUSH=2 ----------------
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("b_jmp", 1, JMP);
    tick();
    nop(1);
    checkCtl("b_jfl1", 1, FLUSH);
    tick();
    checkCtl("b_jfl2", 1, FLUSH);
    tick();
    checkCtl("b_jmp_done", 1, RUN);
    tick();

    // ---------------- reset in the middle of J_FL ----------------
    checkOutput("a_cnt_total", 32'(bus_a.BubbleCnt), 32'd9);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("b_rst_jmp", 1, JMP);
    tick();
    nop(1);
    reset = 1'b1;
    #1;
    checkCtl("b_rst_jfl", 1, FLUSH);
    tick();
    reset = 1'b0;
    #1;
    checkCtl("b_rst_idle", 1, RUN);
    checkOutput("b_rst_cnt", 32'(bus_b.BubbleCnt), 32'd0);
    checkOutput("a_rst_cnt", 32'(bus_a.BubbleCnt), 32'd0);
    tick();
    checkCtl("b_rst_stay_idle", 1, RUN);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
- Parametrised hazard/stall controller for the pipelined MIPS core; next generation of the ID-stage hazard FSM.
- Detects load-use hazards against a configurable load-latency window and sequences jump and branch redirects with configurable flush depth.
- Freezes the front end on a memory-not-ready handshake and counts bubble cycles in a saturating performance counter.
- Drives PC/IF write enables, ID/EX bubble insertion and the next-PC select mux.

Parameters:
- REG_W, 5, register-specifier width.
- LOAD_LAT, 1, load-to-use distance in cycles beyond EX (1..3); a value of 1 matches the single-stall behaviour.
- BR_FLUSH, 1, bubble cycles injected after a taken branch redirect (1..3).
- J_FLUSH, 1, bubble cycles injected after a jump redirect (1..3).
- PERF_W, 16, width of the bubble-cycle counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Jump  in  1  ID holds a jump.
- Branch  in  1  ID holds a conditional branch.
- ALUZero  in  1  EX branch compare result; valid in BR_RES.
- currRs  in  REG_W  ID source rs.
- currRt  in  REG_W  ID source rt.
- UseShamt  in  1  ID instruction ignores rs.
- UseImmed  in  1  ID instruction ignores rt.
- prevRt  in  REG_W  EX destination rt.
- memReadX  in  1  EX instruction is a load.
- MemReady  in  1  data memory ready; 0 freezes controller.
- PCWrite  out  1  PC load enable.
- IFWrite  out  1  IF/ID load enable.
- Bubble  out  1  zero ID/EX control.
- addrSel  out  2  00 = PC+4, 01 = jump target, 10 = branch target, 11 = reserved (never driven).
- BubbleCnt  out  PERF_W  saturating count of Bubble=1 cycles.

Behaviour:
- Reset values: state IDLE, flush counter 0, load history cleared, BubbleCnt 0. Outputs are combinational from state, so during reset PCWrite=1, IFWrite=1, Bubble=0, addrSel=00.
- Load history: shift register of LOAD_LAT-1 entries {valid, dst}.
  - Entry 0 captures {memReadX and prevRt != 0, prevRt} each posedge when MemReady=1; older entries shift.
  - The history holds when MemReady=0.
  - The history is empty when LOAD_LAT=1.
- LdHaz is asserted when any of these hits:
  - the EX stage (memReadX and prevRt != 0) matches;
  - any valid history entry's dst matches.
- A source "matches" when:
  - (!UseShamt and currRs == dst), or
  - (!UseImmed and currRt == dst).
- Register $0 never hazards.
- Freeze rule: if MemReady=0, PCWrite=0, IFWrite=0, Bubble=0, addrSel=00. The FSM state, flush counter and BubbleCnt all hold. This rule overrides all FSM outputs.
- FSM states: IDLE, J_FL, BR_RES, BR_FL.
- IDLE, evaluated in priority order:
  - Jump: PCWrite=1, IFWrite=0, addrSel=01. Next state J_FL, counter = J_FLUSH-1.
  - LdHaz: PCWrite=0, IFWrite=0, Bubble=1. Stay in IDLE. Stall repeats each cycle until the window clears, giving a stall length of LOAD_LAT cycles.
  - Branch: PCWrite=0, IFWrite=0. Next state BR_RES.
  - Otherwise: PCWrite=1, IFWrite=1.
  - LdHaz outranks Branch because a branch needs its operands.
- J_FL:
  - Outputs: Bubble=1, PCWrite=1, IFWrite=1, addrSel=00.
  - When the counter is 0, go to IDLE; otherwise decrement.
- BR_RES:
  - ALUZero=0 (not taken): PCWrite=1, IFWrite=1, Bubble=0, then IDLE.
  - ALUZero=1 (taken): PCWrite=1, IFWrite=0, Bubble=1, addrSel=10. Next state BR_FL, counter = BR_FLUSH-1.
- BR_FL: same outputs and countdown as J_FL.
- BubbleCnt: increments on every cycle with Bubble=1 and MemReady=1; saturates at all-ones with no wrap.
- Reset mid-sequence: synchronous reset returns to IDLE on the next posedge. Any pending flush is abandoned and the history is cleared.
- Jump and Branch both asserted: Jump wins and Branch is ignored.

Decomposition:
- Shared package mips_hazard_pkg holds:
  - state encoding constants S_IDLE, S_J_FL, S_BR_RES, S_BR_FL (2-bit);
  - addrSel constants ADDR_PC4, ADDR_JMP, ADDR_BR.
- One sub-module, load_hazard_window: history shift register plus comparators. It takes LOAD_LAT and REG_W as parameters and outputs LdHaz.
- FSM, counter and perf counter stay in the top module.

Test Plan:
- LOAD_LAT=1: load with prevRt=5, memReadX=1, next instruction currRs=5, UseShamt=0. Required: exactly 1 cycle with Bubble=1, PCWrite=0, IFWrite=0; BubbleCnt=1.
- LOAD_LAT=3: same load-use pair. Required: 3 consecutive stall cycles. Repeat with prevRt=0: no stall.
- BR_FLUSH=2: Branch=1, then ALUZero=1 in BR_RES. Required: addrSel=10 for one cycle, then 2 cycles of Bubble=1, then IDLE. Repeat with ALUZero=0: no Bubble and addrSel stays 00.
- Jump=1 and Branch=1 together, J_FLUSH=1. Required: addrSel=01, then one J_FL bubble cycle; BR_RES is never entered.
- MemReady=0 for 4 cycles during BR_FL. Required: outputs frozen at 0/0/0, counter and BubbleCnt unchanged; sequence resumes after MemReady=1. Separately, Reset=1 mid-J_FL returns to IDLE next cycle.
- PERF_W=4: force 20 bubble cycles. Required: BubbleCnt saturates at 15.
